d_flip_flop: RTL and testbench



---
 rtl/d_flip_flop.sv | 34 +++
 tb/tb_d_flip_flop.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/d_flip_flop.sv
// d_flip_flop: positive-edge storage register with asynchronous active-low
// reset and true/complement outputs. WIDTH independent bits share one clock
// and one reset; there is no interaction between bits.
module d_flip_flop #(
    parameter int unsigned      WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    // Stored true value and a lockstep register holding its complement, so
    // both outputs come straight from flops and qb never lags q.
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qb_r;

    // Capture d and ~d on the rising edge; reset forces both immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_r  <= RESET_VALUE;
            qb_r <= ~RESET_VALUE;
        end else begin
            q_r  <= d;
            qb_r <= ~d;
        end
    end

    assign q  = q_r;
    assign qb = qb_r;

endmodule

// File: tb/tb_d_flip_flop.sv
// Self-checking bench for d_flip_flop: a 1-bit instance and an 8-bit instance
// with reset value 8'hA5 share clock and reset. A behavioural model tracks the
// value each register must hold; a compare process checks every falling edge,
// and directed steps add literal expectations and mid-cycle reset checks.
`timescale 1ns/100ps
module tb_d_flip_flop;

    logic       clk;
    logic       rst;
    logic       d1;
    logic       q1;
    logic       qb1;
    logic [7:0] d8;
    logic [7:0] q8;
    logic [7:0] qb8;

    int checks = 0;
    int errors = 0;

    d_flip_flop u_dut1 (
        .clk (clk),
        .rst (rst),
        .d   (d1),
        .q   (q1),
        .qb  (qb1)
    );

    d_flip_flop #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk (clk),
        .rst (rst),
        .d   (d8),
        .q   (q8),
        .qb  (qb8)
    );

    // 2 ns clock: rising edges at 1, 3, 5 ... ns, falling edges at 2, 4 ... ns.
    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    // Behavioural model: the value each register must currently hold.
    logic       exp1;
    logic [7:0] exp8;
    bit         known = 1'b0;

    // A rising edge with reset released stores whatever d is at that edge.
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            exp1  = d1;
            exp8  = d8;
            known = 1'b1;
        end
    end

    // Reset assertion loads the reset values at once, clock or not.
    always @(negedge rst) begin
        exp1  = 1'b0;
        exp8  = 8'hA5;
        known = 1'b1;
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " q1"},  {7'b0, q1},  {7'b0, exp1});
        check({tag, " qb1"}, {7'b0, qb1}, {7'b0, ~exp1});
        check({tag, " q8"},  q8,  exp8);
        check({tag, " qb8"}, qb8, ~exp8);
    endtask

    // Compare process: outputs are meaningful once the model holds a value.
    always @(negedge clk) begin
        if (known) check_model("cycle");
    end

    initial begin
        rst = 1'b1;
        d1  = 1'b0;
        d8  = 8'h00;

        // Clock with reset released: d = 0 for 10 ns, then d = 1 for 10 ns.
        repeat (5) @(negedge clk);
        check("start q1=0",  {7'b0, q1},  8'h00);
        check("start qb1=1", {7'b0, qb1}, 8'h01);
        d1 = 1'b1;
        repeat (5) @(negedge clk);
        check("d=1 q1=1",  {7'b0, q1},  8'h01);
        check("d=1 qb1=0", {7'b0, qb1}, 8'h00);

        // Toggling data, each value held 10 ns.
        for (int i = 0; i < 4; i++) begin
            d1 = i[0];
            d8 = 8'h11 * 8'(i + 1);
            repeat (5) @(negedge clk);
        end
        check("toggle q1=1", {7'b0, q1}, 8'h01);
        check("toggle q8",   q8, 8'h44);

        // Asynchronous reset halfway between a falling and the next rising edge.
        #0.5;
        rst = 1'b0;
        #0.1;
        check("async q1=0",   {7'b0, q1},  8'h00);
        check("async qb1=1",  {7'b0, qb1}, 8'h01);
        check("async q8=A5",  q8,  8'hA5);
        check("async qb8=5A", qb8, 8'h5A);

        // Reset dominance: 40 ns of alternating data with reset held.
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            d1 = i[0];
            d8 = (i[0] == 1'b1) ? 8'hFF : 8'h3C;
            @(negedge clk);
        end
        check("hold q1=0",  {7'b0, q1}, 8'h00);
        check("hold q8=A5", q8, 8'hA5);

        // Release coincident with a rising edge: that edge must not capture.
        d1 = 1'b1;
        d8 = 8'h3C;
        @(posedge clk);
        rst <= 1'b1;
        @(negedge clk);
        check("release edge q1=0",  {7'b0, q1}, 8'h00);
        check("release edge q8=A5", q8, 8'hA5);
        @(negedge clk);
        check("after release q1=1",  {7'b0, q1}, 8'h01);
        check("after release q8=3C", q8,  8'h3C);
        check("after release qb8",   qb8, 8'hC3);

        // Randomised data with occasional mid-cycle reset pulses.
        for (int i = 0; i < 400; i++) begin
            d1 = 1'($urandom);
            d8 = 8'($urandom);
            if ($urandom_range(19, 0) == 0) begin
                #0.5;
                rst = 1'b0;
                #0.1;
                check_model("rand async");
                repeat ($urandom_range(3, 1)) @(negedge clk);
                rst = 1'b1;
            end
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
